// File: rtl/lift_row_seq.sv
// -----------------------------------------------------------------------------
// lift_row_seq
// Row sequencer for a 5/3 lifting wavelet. A full row of samples is buffered,
// then two in-place lifting passes are issued to an external lift_step unit
// (one operand triple at a time). The finished coefficients are then streamed
// out in interleaved order (even = low-pass, odd = high-pass).
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   inv_i                         0 = forward 5/3, 1 = inverse (latched at row start)
//   pix_i, pix_hi_i               sample byte, and coefficient MSB (inverse only)
//   pix_valid_i / pix_ready_o     input handshake
//   left_o, sam_o, right_o        lift_step operands x[i-1], x[i], x[i+1]
//   flags_o                       lift_step op: 7 fwd predict, 5 fwd update,
//                                 4 inv update, 6 inv predict
//   update_o                      one-cycle issue strobe to lift_step
//   res_i, res_valid_i            lift_step result and its strobe
//   coef_o, coef_valid_o / coef_ready_i   output coefficient handshake
//   busy_o                        high whenever a row is in flight
// -----------------------------------------------------------------------------
module lift_row_seq #(
  parameter int ROW_LEN = 16,  // samples per row; even, >= 4
  parameter int RES_W   = 9    // signed coefficient width
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inv_i,
  input  logic [7:0]       pix_i,
  input  logic             pix_hi_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  output logic [RES_W-1:0] left_o,
  output logic [RES_W-1:0] sam_o,
  output logic [RES_W-1:0] right_o,
  output logic [3:0]       flags_o,
  output logic             update_o,
  input  logic [RES_W-1:0] res_i,
  input  logic             res_valid_i,
  output logic [RES_W-1:0] coef_o,
  output logic             coef_valid_o,
  input  logic             coef_ready_i,
  output logic             busy_o
);

  localparam int IDX_W = $clog2(ROW_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);
  localparam logic [IDX_W-1:0] PEN_IDX  = IDX_W'(ROW_LEN - 2);

  typedef enum logic [2:0] {
    IDLE, LOAD, S1_ISSUE, S1_WAIT, S2_ISSUE, S2_WAIT, DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic             inv_q, inv_d;
  // One index serves as load pointer, lifting position and drain pointer.
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [RES_W-1:0] row_q [ROW_LEN];
  logic             wr_en;
  logic [RES_W-1:0] wr_data;

  logic [IDX_W-1:0] left_idx, right_idx;
  logic [RES_W-1:0] load_sample;
  logic             pass2;
  logic [3:0]       op_flags;

  // Symmetric extension at the row edges: x[-1] -> x[1], x[N] -> x[N-2].
  assign left_idx  = (idx_q == '0)      ? IDX_W'(1) : idx_q - IDX_W'(1);
  assign right_idx = (idx_q == LAST_IDX) ? PEN_IDX  : idx_q + IDX_W'(1);

  // Forward samples are unsigned pixels; inverse samples are signed 9-bit
  // coefficients split across pix_hi_i/pix_i.
  assign load_sample = inv_q ? RES_W'($signed({pix_hi_i, pix_i}))
                             : RES_W'(pix_i);

  assign pass2    = (state_q == S2_ISSUE) || (state_q == S2_WAIT);
  // Forward: predict (odd) then update (even). Inverse runs the reverse order.
  assign op_flags = pass2 ? (inv_q ? 4'd6 : 4'd5)
                          : (inv_q ? 4'd4 : 4'd7);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, exactly like the hardware.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      inv_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the row buffer has no reset; every entry is rewritten by LOAD before
  // it is read, so clearing it would only cost reset fan-out. Writes are still
  // blocked while rst_i is high so reset wins over a same-cycle result.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      row_q[idx_q] <= wr_data;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    inv_d        = inv_q;
    idx_d        = idx_q;
    wr_en        = 1'b0;
    wr_data      = load_sample;
    pix_ready_o  = 1'b0;
    update_o     = 1'b0;
    coef_valid_o = 1'b0;
    coef_o       = '0;
    busy_o       = 1'b1;
    flags_o      = '0;
    left_o       = '0;
    sam_o        = '0;
    right_o      = '0;

    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        // The first sample only opens the row; it is taken in LOAD.
        if (pix_valid_i) begin
          inv_d   = inv_i;
          idx_d   = '0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        pix_ready_o = 1'b1;
        if (pix_valid_i) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = inv_q ? '0 : IDX_W'(1);
            state_d = S1_ISSUE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S1_ISSUE, S2_ISSUE: begin
        update_o = 1'b1;
        flags_o  = op_flags;
        left_o   = row_q[left_idx];
        sam_o    = row_q[idx_q];
        right_o  = row_q[right_idx];
        state_d  = pass2 ? S2_WAIT : S1_WAIT;
      end

      S1_WAIT, S2_WAIT: begin
        // Operands come straight from the buffer, which cannot change until
        // the result lands, so they stay stable for the whole wait.
        flags_o = op_flags;
        left_o  = row_q[left_idx];
        sam_o   = row_q[idx_q];
        right_o = row_q[right_idx];
        if (res_valid_i) begin
          wr_en   = 1'b1;
          wr_data = res_i;
          if (idx_q < PEN_IDX) begin
            idx_d   = idx_q + IDX_W'(2);
            state_d = pass2 ? S2_ISSUE : S1_ISSUE;
          end else if (!pass2) begin
            idx_d   = inv_q ? IDX_W'(1) : '0;
            state_d = S2_ISSUE;
          end else begin
            idx_d   = '0;
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        coef_valid_o = 1'b1;
        coef_o       = row_q[idx_q];
        if (coef_ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lift_row_seq.sv
// -----------------------------------------------------------------------------
// tb_lift_row_seq
// Self-checking bench for lift_row_seq (ROW_LEN=4, RES_W=9). A behavioural
// lift_step responder answers each issue after a programmable latency; a
// row-level 5/3 reference model predicts the coefficients of every row.
// -----------------------------------------------------------------------------
module tb_lift_row_seq;

  localparam int N  = 4;
  localparam int RW = 9;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          inv_i;
  logic [7:0]    pix_i;
  logic          pix_hi_i;
  logic          pix_valid_i;
  logic          pix_ready_o;
  logic [RW-1:0] left_o, sam_o, right_o;
  logic [3:0]    flags_o;
  logic          update_o;
  logic [RW-1:0] res_i;
  logic          res_valid_i;
  logic [RW-1:0] coef_o;
  logic          coef_valid_o;
  logic          coef_ready_i;
  logic          busy_o;

  int checks   = 0;
  int failures = 0;

  // Responder controls (written by main only) and responder status.
  int res_lat    = 2;
  int mute_flags = -1;
  int stray_req  = 0;
  int stray_done = 0;
  int mute_hits  = 0;
  int iss_flags[$];
  int iss_left[$];
  int iss_sam[$];
  int iss_right[$];

  always #5 clk = ~clk;

  lift_row_seq #(.ROW_LEN(N), .RES_W(RW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .inv_i        (inv_i),
    .pix_i        (pix_i),
    .pix_hi_i     (pix_hi_i),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .left_o       (left_o),
    .sam_o        (sam_o),
    .right_o      (right_o),
    .flags_o      (flags_o),
    .update_o     (update_o),
    .res_i        (res_i),
    .res_valid_i  (res_valid_i),
    .coef_o       (coef_o),
    .coef_valid_o (coef_valid_o),
    .coef_ready_i (coef_ready_i),
    .busy_o       (busy_o)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reinterpret an integer as an RW-bit two's complement value.
  function automatic int wrap(input int v);
    logic [RW-1:0] t;
    t = v[RW-1:0];
    return int'($signed(t));
  endfunction

  // lift_step behaviour: floor-based 5/3 predict/update steps.
  function automatic int lift(input int fl, input int l, input int s, input int r);
    case (fl)
      7:       return wrap(s - ((l + r) >>> 1));
      5:       return wrap(s + ((l + r + 2) >>> 2));
      4:       return wrap(s - ((l + r + 2) >>> 2));
      6:       return wrap(s + ((l + r) >>> 1));
      default: return 0;
    endcase
  endfunction

  // Whole-row reference: in-place lifting over an array with mirrored edges.
  function automatic void ref_row(input bit inv, input int x_in[N], output int y[N]);
    int x[N];
    int l, r, start, fl;
    x = x_in;
    for (int p = 0; p < 2; p++) begin
      start = (inv != (p == 1)) ? 0 : 1;
      fl    = inv ? ((p == 0) ? 4 : 6) : ((p == 0) ? 7 : 5);
      for (int i = start; i < N; i += 2) begin
        l    = (i == 0)     ? x[1]     : x[i-1];
        r    = (i == N - 1) ? x[N - 2] : x[i+1];
        x[i] = lift(fl, l, x[i], r);
      end
    end
    y = x;
  endfunction

  // Behavioural lift_step: answers each issue after res_lat cycles, checks the
  // issue strobe is single-cycle and operands stay put while it waits.
  initial begin : responder
    int f, l, s, r;
    logic [30:0] held;
    res_valid_i = 1'b0;
    res_i       = '0;
    forever begin
      @(negedge clk);
      res_valid_i = 1'b0;
      if (stray_req != stray_done) begin
        stray_done++;
        res_i       = RW'($urandom);
        res_valid_i = 1'b1;
      end else if (update_o === 1'b1) begin
        f    = int'(flags_o);
        l    = $signed(left_o);
        s    = $signed(sam_o);
        r    = $signed(right_o);
        held = {flags_o, left_o, sam_o, right_o};
        iss_flags.push_back(f);
        iss_left.push_back(l);
        iss_sam.push_back(s);
        iss_right.push_back(r);
        if (f == mute_flags) begin
          mute_hits++;
        end else begin
          for (int c = 0; c < res_lat; c++) begin
            @(negedge clk);
            check("update_single_cycle", update_o, 0);
            check("operands_held", {flags_o, left_o, sam_o, right_o}, held);
          end
          res_i       = RW'(lift(f, l, s, r));
          res_valid_i = 1'b1;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_update",     update_o,     0);
    check("rst_pix_ready",  pix_ready_o,  0);
    check("rst_coef_valid", coef_valid_o, 0);
    check("rst_busy",       busy_o,       0);
    check("rst_flags",      flags_o,      0);
    check("rst_left",       left_o,       0);
    check("rst_sam",        sam_o,        0);
    check("rst_right",      right_o,      0);
    check("rst_coef",       coef_o,       0);
  endtask

  // Starts and ends on a negedge. Late inv_i flips must be ignored.
  task automatic send_row(input bit inv, input int x[N], input bit gaps,
                          output int idle_cyc);
    int budget;
    idle_cyc = 0;
    inv_i    = inv;
    for (int j = 0; j < N; j++) begin
      if (gaps && j > 0 && $urandom_range(0, 1) == 1) begin
        pix_valid_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      pix_valid_i = 1'b1;
      pix_i       = x[j][7:0];
      pix_hi_i    = inv ? x[j][8] : 1'($urandom_range(0, 1));
      budget      = 100;
      while (!pix_ready_o && budget > 0) begin
        if (j == 0 && !busy_o) idle_cyc++;
        @(negedge clk);
        budget--;
      end
      if (budget == 0) begin
        check("load_timeout", 0, 1);
        pix_valid_i = 1'b0;
        return;
      end
      @(negedge clk);
      if (j == 0) inv_i = ~inv;
    end
    pix_valid_i = 1'b0;
  endtask

  task automatic drain_row(input bit toggle, output int got[N]);
    int k, budget;
    bit prev_stall;
    logic [RW-1:0] saved;
    k          = 0;
    budget     = 1000;
    prev_stall = 1'b0;
    saved      = '0;
    for (int i = 0; i < N; i++) got[i] = 0;
    while (k < N && budget > 0) begin
      coef_ready_i = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (coef_valid_o) begin
        if (prev_stall) check("coef_stable", coef_o, saved);
        if (coef_ready_i) begin
          got[k]     = $signed(coef_o);
          k++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          saved      = coef_o;
        end
      end
      @(negedge clk);
      budget--;
    end
    coef_ready_i = 1'b0;
    if (k < N) check("drain_timeout", k, N);
  endtask

  task automatic run_row(input bit inv, input int x[N], input bit gaps,
                         input bit toggle, output int got[N]);
    int idle_cyc;
    send_row(inv, x, gaps, idle_cyc);
    check("busy_low_one_cycle", idle_cyc, 1);
    drain_row(toggle, got);
    check("idle_after_drain", busy_o, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int row[N], got[N], exp_row[N], fwd_row[N], inv_row[N], fwd_exp[N];
    int base, hits0, budget, cnt0;
    bit inv;

    rst_i        = 1'b1;
    inv_i        = 1'b0;
    pix_i        = '0;
    pix_hi_i     = 1'b0;
    pix_valid_i  = 1'b0;
    coef_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_i = 1'b0;
    @(negedge clk);

    fwd_row = '{68, 218, 163, 250};
    fwd_exp = '{120, 103, 211, 87};
    inv_row = '{120, 103, 211, 87};

    // Forward reference row with issue order and edge mirroring.
    res_lat = 2;
    base    = iss_flags.size();
    run_row(1'b0, fwd_row, 1'b0, 1'b0, got);
    for (int i = 0; i < N; i++) check("fwd_coef", got[i], fwd_exp[i]);
    check("fwd_issue_count", iss_flags.size() - base, 4);
    check("fwd_flags0", iss_flags[base+0], 7);
    check("fwd_flags1", iss_flags[base+1], 7);
    check("fwd_flags2", iss_flags[base+2], 5);
    check("fwd_flags3", iss_flags[base+3], 5);
    check("fwd_sam_i1", iss_sam[base+0], 218);
    check("fwd_sam_i3", iss_sam[base+1], 250);
    check("fwd_sam_i0", iss_sam[base+2], 68);
    check("fwd_sam_i2", iss_sam[base+3], 163);
    check("edge_i3_left",  iss_left[base+1],  163);
    check("edge_i3_right", iss_right[base+1], 163);
    check("edge_i0_left",  iss_left[base+2],  103);
    check("edge_i0_right", iss_right[base+2], 103);

    // Inverse reference row, immediately back to back with the forward row.
    base = iss_flags.size();
    run_row(1'b1, inv_row, 1'b0, 1'b0, got);
    for (int i = 0; i < N; i++) check("inv_coef", got[i], fwd_row[i]);
    check("inv_issue_count", iss_flags.size() - base, 4);
    check("inv_flags0", iss_flags[base+0], 4);
    check("inv_flags1", iss_flags[base+1], 4);
    check("inv_flags2", iss_flags[base+2], 6);
    check("inv_flags3", iss_flags[base+3], 6);

    // Backpressure everywhere and a slow lift_step.
    res_lat = 10;
    run_row(1'b0, fwd_row, 1'b1, 1'b1, got);
    for (int i = 0; i < N; i++) check("bp_coef", got[i], fwd_exp[i]);
    res_lat = 2;

    // Reset while waiting on a pass-2 result, then a stray result strobe.
    mute_flags = 5;
    hits0      = mute_hits;
    send_row(1'b0, fwd_row, 1'b0, cnt0);
    budget = 200;
    while (mute_hits == hits0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("mute_wait_timeout", 0, 1);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst_i      = 1'b0;
    mute_flags = -1;
    cnt0       = iss_flags.size();
    stray_req++;
    repeat (4) begin
      @(negedge clk);
      check("no_issue_after_rst", update_o, 0);
      check("idle_after_rst", busy_o, 0);
    end
    check("stray_issue_count", iss_flags.size(), cnt0);
    run_row(1'b0, fwd_row, 1'b0, 1'b0, got);
    for (int i = 0; i < N; i++) check("post_rst_coef", got[i], fwd_exp[i]);

    // Back-to-back forward then inverse.
    run_row(1'b0, fwd_row, 1'b0, 1'b0, got);
    for (int i = 0; i < N; i++) check("b2b_fwd_coef", got[i], fwd_exp[i]);
    run_row(1'b1, inv_row, 1'b0, 1'b0, got);
    for (int i = 0; i < N; i++) check("b2b_inv_coef", got[i], fwd_row[i]);

    // Randomized rows against the row-level reference model.
    for (int t = 0; t < 20; t++) begin
      inv = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        row[i] = inv ? wrap(int'($urandom_range(0, 511))) : int'($urandom_range(0, 255));
      ref_row(inv, row, exp_row);
      res_lat = int'($urandom_range(1, 4));
      base    = iss_flags.size();
      run_row(inv, row, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
      for (int i = 0; i < N; i++) check("rand_coef", got[i], exp_row[i]);
      check("rand_issue_count", iss_flags.size() - base, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
